// File: rtl/cache_access_arbiter.sv
// Round-robin front end sharing one cache model among NUM_REQ requesters.
// Issues a single access at a time and models miss/writeback latency.
module cache_access_arbiter #(
    parameter int NUM_REQ      = 2,
    parameter int ADDRESS_SIZE = 16,
    parameter int MISS_PENALTY = 4,
    parameter int WB_PENALTY   = 2,
    parameter int CNT_WIDTH    = 32
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ-1:0]              req_rw,
    input  logic [NUM_REQ*ADDRESS_SIZE-1:0] req_addr,
    output logic [NUM_REQ-1:0]              req_ready,
    output logic [NUM_REQ-1:0]              resp_valid,
    output logic                            resp_hit,
    output logic                            cache_en,
    output logic                            cache_rw,
    output logic [ADDRESS_SIZE-1:0]         cache_address,
    input  logic                            cache_hit,
    input  logic                            cache_miss,
    input  logic                            cache_writeback,
    output logic [$clog2(NUM_REQ)-1:0]      grant_id,
    output logic                            busy,
    output logic [CNT_WIDTH-1:0]            num_requests,
    output logic [CNT_WIDTH-1:0]            miss_cycles,
    output logic                            proto_err
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(MISS_PENALTY + WB_PENALTY + 1);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        LOOKUP,
        MISS_WAIT,
        RESPOND
    } state_t;

    state_t         state;
    state_t         next_state;
    logic [IW-1:0]  rr_ptr;
    logic [IW-1:0]  gnt_idx;
    logic [IW-1:0]  idx;
    logic           gnt_any;
    logic           accept;
    logic           hit_q;
    logic [CW-1:0]  cnt;

    function automatic logic [IW-1:0] wrap_add(logic [IW-1:0] a, int k);
        int s;
        s = int'(a) + k;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return IW'(s);
    endfunction

    // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        idx     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = wrap_add(rr_ptr, k);
            if (!gnt_any && req_valid[idx]) begin
                gnt_any = 1'b1;
                gnt_idx = idx;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        accept     = 1'b0;
        unique case (state)
            IDLE: begin
                if (gnt_any) begin
                    accept     = 1'b1;
                    next_state = ISSUE;
                end
            end
            ISSUE: next_state = LOOKUP;
            LOOKUP: begin
                if (cache_hit)       next_state = RESPOND;
                else if (cache_miss) next_state = MISS_WAIT;
            end
            MISS_WAIT: begin
                if (cnt == CW'(1)) next_state = RESPOND;
            end
            RESPOND: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Gated by reset so nothing is offered while reset is held
    always_comb begin
        req_ready = '0;
        if (reset && state == IDLE && gnt_any) req_ready[gnt_idx] = 1'b1;
    end

    always_comb begin
        resp_valid = '0;
        for (int i = 0; i < NUM_REQ; i++)
            resp_valid[i] = (state == RESPOND) && (grant_id == IW'(i));
    end

    assign resp_hit = (state == RESPOND) && hit_q;
    assign cache_en = (state == ISSUE);
    assign busy     = (state != IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cache_rw      <= 1'b0;
            cache_address <= '0;
            grant_id      <= '0;
            rr_ptr        <= '0;
            hit_q         <= 1'b0;
            cnt           <= '0;
            num_requests  <= '0;
            miss_cycles   <= '0;
            proto_err     <= 1'b0;
        end else begin
            if (accept) begin
                cache_rw      <= req_rw[gnt_idx];
                cache_address <= req_addr[int'(gnt_idx)*ADDRESS_SIZE +: ADDRESS_SIZE];
                grant_id      <= gnt_idx;
                hit_q         <= 1'b0;
                if (num_requests != '1)
                    num_requests <= num_requests + 1'b1;
            end
            if (state == LOOKUP) begin
                if (cache_hit) begin
                    hit_q <= 1'b1;
                    if (cache_miss) proto_err <= 1'b1;
                end else if (cache_miss) begin
                    hit_q <= 1'b0;
                    cnt   <= cache_writeback ? CW'(MISS_PENALTY + WB_PENALTY)
                                             : CW'(MISS_PENALTY);
                end
            end
            if (state == MISS_WAIT) begin
                cnt <= cnt - 1'b1;
                if (miss_cycles != '1)
                    miss_cycles <= miss_cycles + 1'b1;
            end
            if (state == RESPOND)
                rr_ptr <= wrap_add(grant_id, 1);
        end
    end

endmodule

// File: tb/tb_cache_access_arbiter.sv
// Directed bench for cache_access_arbiter: reset, hit/miss latency,
// round-robin order, reset mid-access and protocol error flag.
module tb_cache_access_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req_valid;
    logic [1:0]  req_rw;
    logic [31:0] req_addr;
    logic [1:0]  req_ready;
    logic [1:0]  resp_valid;
    logic        resp_hit;
    logic        cache_en;
    logic        cache_rw;
    logic [15:0] cache_address;
    logic        cache_hit;
    logic        cache_miss;
    logic        cache_writeback;
    logic [0:0]  grant_id;
    logic        busy;
    logic [31:0] num_requests;
    logic [31:0] miss_cycles;
    logic        proto_err;

    int vec  = 0;
    int errs = 0;

    always #5 clk = ~clk;

    cache_access_arbiter dut (
        .clk             (clk),
        .reset           (reset),
        .req_valid       (req_valid),
        .req_rw          (req_rw),
        .req_addr        (req_addr),
        .req_ready       (req_ready),
        .resp_valid      (resp_valid),
        .resp_hit        (resp_hit),
        .cache_en        (cache_en),
        .cache_rw        (cache_rw),
        .cache_address   (cache_address),
        .cache_hit       (cache_hit),
        .cache_miss      (cache_miss),
        .cache_writeback (cache_writeback),
        .grant_id        (grant_id),
        .busy            (busy),
        .num_requests    (num_requests),
        .miss_cycles     (miss_cycles),
        .proto_err       (proto_err)
    );

    task automatic clear_inputs;
        req_valid       = '0;
        req_rw          = '0;
        req_addr        = '0;
        cache_hit       = 1'b0;
        cache_miss      = 1'b0;
        cache_writeback = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            req_valid       = 2'($urandom);
            req_rw          = 2'($urandom);
            req_addr        = $urandom;
            cache_hit       = 1'($urandom);
            cache_miss      = 1'($urandom);
            cache_writeback = 1'($urandom);
            #1;
            vec++;
            if ({req_ready, resp_valid, resp_hit, cache_en, cache_rw, cache_address,
                 grant_id, busy, num_requests, miss_cycles, proto_err} !== '0) begin
                errs++;
                $display("FAIL reset_outputs cyc %0d: rdy=%b rv=%b en=%b addr=%h busy=%b nreq=%0d",
                         i, req_ready, resp_valid, cache_en, cache_address, busy, num_requests);
            end
        end
        @(negedge clk);
        clear_inputs();
        reset = 1'b1;
        #1;
        vec++;
        if (busy !== 1'b0 || req_ready !== 2'b00) begin
            errs++;
            $display("FAIL reset_release: busy=%b rdy=%b, want 0 00", busy, req_ready);
        end
    endtask

    task automatic test_hit;
        @(negedge clk);
        req_valid = 2'b01;
        req_rw    = 2'b00;
        req_addr[15:0] = 16'h1230;
        cache_hit = 1'b1;
        #1;
        vec++;
        if (req_ready !== 2'b01) begin
            errs++;
            $display("FAIL hit_ready: got %b want 01", req_ready);
        end
        @(negedge clk);
        req_valid = 2'b00;
        #1;
        vec++;
        if (cache_en !== 1'b1 || cache_address !== 16'h1230 || cache_rw !== 1'b0
            || grant_id !== 1'b0 || busy !== 1'b1) begin
            errs++;
            $display("FAIL hit_issue: en=%b addr=%h rw=%b gid=%0d busy=%b",
                     cache_en, cache_address, cache_rw, grant_id, busy);
        end
        @(negedge clk);
        #1;
        vec++;
        if (cache_en !== 1'b0 || resp_valid !== 2'b00) begin
            errs++;
            $display("FAIL hit_lookup: en=%b rv=%b want 0 00", cache_en, resp_valid);
        end
        @(negedge clk);
        #1;
        vec++;
        if (resp_valid !== 2'b01 || resp_hit !== 1'b1 || num_requests !== 32'd1) begin
            errs++;
            $display("FAIL hit_resp: rv=%b hit=%b nreq=%0d want 01 1 1",
                     resp_valid, resp_hit, num_requests);
        end
        @(negedge clk);
        #1;
        vec++;
        if (busy !== 1'b0 || resp_valid !== 2'b00) begin
            errs++;
            $display("FAIL hit_idle: busy=%b rv=%b want 0 00", busy, resp_valid);
        end
    endtask

    task automatic test_miss(input logic wb, input int exp_lat, input int exp_mc);
        @(negedge clk);
        req_valid = 2'b01;
        req_rw    = 2'b01;
        req_addr[15:0] = 16'hBEEF;
        cache_hit       = 1'b0;
        cache_miss      = 1'b1;
        cache_writeback = wb;
        #1;
        vec++;
        if (req_ready !== 2'b01) begin
            errs++;
            $display("FAIL miss_ready wb=%b: got %b want 01", wb, req_ready);
        end
        for (int c = 1; c <= exp_lat + 1; c++) begin
            @(negedge clk);
            if (c == 1) req_valid = 2'b00;
            #1;
            vec++;
            if (resp_valid !== ((c == exp_lat) ? 2'b01 : 2'b00)) begin
                errs++;
                $display("FAIL miss_resp_timing wb=%b cyc %0d: rv=%b", wb, c, resp_valid);
            end
            if (c == exp_lat) begin
                vec++;
                if (resp_hit !== 1'b0 || miss_cycles !== 32'(exp_mc)
                    || cache_rw !== 1'b1 || cache_address !== 16'hBEEF) begin
                    errs++;
                    $display("FAIL miss_resp wb=%b: hit=%b mc=%0d rw=%b addr=%h want 0 %0d 1 beef",
                             wb, resp_hit, miss_cycles, cache_rw, cache_address, exp_mc);
                end
            end
        end
    endtask

    task automatic test_round_robin;
        logic [1:0] exp_rdy;
        @(negedge clk);
        reset = 1'b0;
        clear_inputs();
        @(negedge clk);
        reset = 1'b1;
        cache_hit = 1'b1;
        for (int c = 0; c <= 15; c++) begin
            @(negedge clk);
            if (c == 0)  req_valid = 2'b11;
            if (c == 13) req_valid = 2'b00;
            #1;
            exp_rdy = 2'b00;
            if (c % 4 == 0 && c <= 12)
                exp_rdy = ((c / 4) % 2 == 0) ? 2'b01 : 2'b10;
            vec++;
            if (req_ready !== exp_rdy) begin
                errs++;
                $display("FAIL rr_ready cyc %0d: got %b want %b", c, req_ready, exp_rdy);
            end
            if (c % 4 == 1) begin
                vec++;
                if (grant_id !== 1'((c / 4) % 2)) begin
                    errs++;
                    $display("FAIL rr_grant cyc %0d: got %0d want %0d", c, grant_id, (c / 4) % 2);
                end
            end
        end
        @(negedge clk);
        #1;
        vec++;
        if (num_requests !== 32'd4 || busy !== 1'b0) begin
            errs++;
            $display("FAIL rr_count: nreq=%0d busy=%b want 4 0", num_requests, busy);
        end
    endtask

    task automatic test_reset_midaccess;
        // hit from req 0 moves rr_ptr to 1
        @(negedge clk);
        req_valid = 2'b01;
        cache_hit = 1'b1;
        cache_miss = 1'b0;
        @(negedge clk);
        req_valid = 2'b00;
        repeat (3) @(negedge clk);
        // miss from req 0, reset during second MISS_WAIT cycle
        req_valid = 2'b01;
        req_addr[15:0] = 16'h4444;
        cache_hit  = 1'b0;
        cache_miss = 1'b1;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        #1;
        vec++;
        if (busy !== 1'b0 || cache_address !== 16'h0 || num_requests !== 32'd0
            || req_ready !== 2'b00 || miss_cycles !== 32'd0 || grant_id !== 1'b0) begin
            errs++;
            $display("FAIL midreset_outputs: busy=%b addr=%h nreq=%0d rdy=%b mc=%0d",
                     busy, cache_address, num_requests, req_ready, miss_cycles);
        end
        repeat (2) @(negedge clk);
        req_valid = 2'b00;
        reset = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            #1;
            vec++;
            if (resp_valid !== 2'b00 || busy !== 1'b0) begin
                errs++;
                $display("FAIL midreset_noresp cyc %0d: rv=%b busy=%b", c, resp_valid, busy);
            end
        end
        @(negedge clk);
        req_valid  = 2'b11;
        cache_hit  = 1'b1;
        cache_miss = 1'b0;
        #1;
        vec++;
        if (req_ready !== 2'b01) begin
            errs++;
            $display("FAIL midreset_grant: rdy=%b want 01", req_ready);
        end
        @(negedge clk);
        req_valid = 2'b00;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_proto_err;
        @(negedge clk);
        req_valid  = 2'b01;
        cache_hit  = 1'b1;
        cache_miss = 1'b1;
        #1;
        vec++;
        if (proto_err !== 1'b0 || req_ready !== 2'b01) begin
            errs++;
            $display("FAIL perr_start: perr=%b rdy=%b want 0 01", proto_err, req_ready);
        end
        @(negedge clk);
        req_valid = 2'b00;
        repeat (2) @(negedge clk);
        #1;
        vec++;
        if (resp_valid !== 2'b01 || resp_hit !== 1'b1 || proto_err !== 1'b1) begin
            errs++;
            $display("FAIL perr_resp: rv=%b hit=%b perr=%b want 01 1 1",
                     resp_valid, resp_hit, proto_err);
        end
        @(negedge clk);
        req_valid  = 2'b01;
        cache_miss = 1'b0;
        @(negedge clk);
        req_valid = 2'b00;
        repeat (4) @(negedge clk);
        #1;
        vec++;
        if (proto_err !== 1'b1 || busy !== 1'b0) begin
            errs++;
            $display("FAIL perr_sticky: perr=%b busy=%b want 1 0", proto_err, busy);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        vec++;
        if (proto_err !== 1'b0) begin
            errs++;
            $display("FAIL perr_clear: perr=%b want 0", proto_err);
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_hit();
        test_miss(1'b0, 7, 4);
        test_miss(1'b1, 9, 10);
        test_round_robin();
        test_reset_midaccess();
        test_proto_err();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
